// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
//   Avalon-MM controlled sequencer for an 8-bit LED bank. Software programs
//   mode, seed pattern and step period; the block then steps the pattern on
//   its own. Optional push-button pause/resume when LED_PATTERN_BUTTON_EN is
//   defined (otherwise `button` is ignored and HOLD is never entered).
//
// Ports
//   clk, reset          : system clock, synchronous active-high reset
//   avs_s0_address[1:0] : 0 CTRL, 1 PATTERN, 2 PERIOD, 3 STATUS
//   avs_s0_read/write   : read / write strobes
//   avs_s0_writedata    : write data
//   avs_s0_readdata     : registered read data (valid the cycle after read)
//   button[3:0]         : active-low asynchronous push-buttons (bit 0 used)
//   leds[7:0]           : active-high LED drive
module led_pattern_ctrl #(
  parameter int unsigned DEFAULT_PERIOD  = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_writedata,
  output logic [31:0] avs_s0_readdata,
  input  logic [3:0]  button,
  output logic [7:0]  leds
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  state_t      state_q, state_d;
  logic        run_q;
  logic [1:0]  mode_q;
  logic [31:0] period_q;
  logic [31:0] presc_q;
  logic [15:0] step_cnt_q;
  logic        dir_q;          // 0 = left, 1 = right
  logic [7:0]  leds_q;

  logic        wr_ctrl, wr_pat, wr_per, reg_write;
  logic [31:0] period_m1;
  logic        presc_match;
  logic        presc_run;
  logic        step_en;
  logic        start_run;
  logic        press;

  assign wr_ctrl   = avs_s0_write && (avs_s0_address == 2'd0);
  assign wr_pat    = avs_s0_write && (avs_s0_address == 2'd1);
  assign wr_per    = avs_s0_write && (avs_s0_address == 2'd2);
  assign reg_write = wr_ctrl || wr_pat || wr_per;

  // PERIOD of 0 behaves as 1, so the match value is max(PERIOD,1)-1.
  assign period_m1   = (period_q == '0) ? '0 : period_q - 32'd1;
  assign presc_match = (presc_q == period_m1);

`ifdef LED_PATTERN_BUTTON_EN
  logic [3:0]  sync1_q, sync2_q;
  logic        raw_press;
  logic        acc_q, acc_prev_q;
  logic [31:0] db_cnt_q;
  logic        unused_sync;

  assign raw_press   = ~sync2_q[0];
  assign unused_sync = ^sync2_q[3:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      acc_q      <= 1'b0;
      acc_prev_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= button;
      sync2_q    <= sync1_q;
      acc_prev_q <= acc_q;
      if (raw_press == acc_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == 32'(DEBOUNCE_CYCLES - 1)) begin
        acc_q    <= raw_press;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 32'd1;
      end
    end
  end

  assign press = acc_q && !acc_prev_q;
`else
  logic unused_button;
  assign unused_button = ^button;
  assign press         = 1'b0;
`endif

  // Next state and step qualification. A CTRL write in the same cycle as a
  // press takes priority and the press is discarded.
  always_comb begin
    state_d   = state_q;
    presc_run = 1'b0;
    step_en   = 1'b0;
    start_run = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_ctrl && avs_s0_writedata[0]) begin
          state_d   = S_RUN;
          start_run = 1'b1;
        end
      end
      S_RUN: begin
        presc_run = 1'b1;
        step_en   = presc_match && !reg_write;
        if (wr_ctrl) begin
          if (!avs_s0_writedata[0]) state_d = S_IDLE;
        end else if (press) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (wr_ctrl) begin
          if (!avs_s0_writedata[0]) state_d = S_IDLE;
        end else if (press) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Registers, prescaler and pattern datapath. A write landing on a due
  // step suppresses the step; the prescaler still wraps to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q      <= 1'b0;
      mode_q     <= MODE_STATIC;
      period_q   <= 32'(DEFAULT_PERIOD);
      presc_q    <= '0;
      step_cnt_q <= '0;
      dir_q      <= 1'b0;
      leds_q     <= '0;
    end else begin
      if (wr_ctrl) begin
        run_q  <= avs_s0_writedata[0];
        mode_q <= avs_s0_writedata[2:1];
      end
      if (wr_per) period_q <= avs_s0_writedata;

      if (wr_per || start_run) presc_q <= '0;
      else if (presc_run)      presc_q <= presc_match ? '0 : presc_q + 32'd1;

      if (start_run)    step_cnt_q <= '0;
      else if (step_en) step_cnt_q <= step_cnt_q + 16'd1;

      if (wr_ctrl && (avs_s0_writedata[2:1] != mode_q)) begin
        dir_q <= 1'b0;
      end else if (step_en && (mode_q == MODE_BOUNCE) && (leds_q != '0)) begin
        if (!dir_q && leds_q[7])     dir_q <= 1'b1;
        else if (dir_q && leds_q[0]) dir_q <= 1'b0;
      end

      if (wr_pat) begin
        leds_q <= avs_s0_writedata[7:0];
      end else if (step_en) begin
        case (mode_q)
          MODE_STATIC: leds_q <= leds_q;
          MODE_ROTATE: leds_q <= {leds_q[6:0], leds_q[7]};
          MODE_BOUNCE: begin
            if (!dir_q) leds_q <= leds_q[7] ? (leds_q >> 1) : (leds_q << 1);
            else        leds_q <= leds_q[0] ? (leds_q << 1) : (leds_q >> 1);
          end
          MODE_COUNT:  leds_q <= leds_q + 8'd1;
          default:     leds_q <= leds_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avs_s0_readdata <= '0;
    end else if (avs_s0_read) begin
      case (avs_s0_address)
        2'd0:    avs_s0_readdata <= {29'd0, mode_q, run_q};
        2'd1:    avs_s0_readdata <= {24'd0, leds_q};
        2'd2:    avs_s0_readdata <= period_q;
        default: avs_s0_readdata <= {step_cnt_q, leds_q, 6'd0,
                                     state_q == S_HOLD, state_q == S_RUN};
      endcase
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  avs_s0_address;
  logic        avs_s0_read;
  logic        avs_s0_write;
  logic [31:0] avs_s0_writedata;
  logic [31:0] avs_s0_readdata;
  logic [3:0]  button;
  logic [7:0]  leds;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  led_pattern_ctrl #(
    .DEFAULT_PERIOD (10),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .avs_s0_address  (avs_s0_address),
    .avs_s0_read     (avs_s0_read),
    .avs_s0_write    (avs_s0_write),
    .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_readdata (avs_s0_readdata),
    .button          (button),
    .leds            (leds)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge after the write edge.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    avs_s0_address   = addr;
    avs_s0_writedata = data;
    avs_s0_write     = 1'b1;
    @(negedge clk);
    avs_s0_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    avs_s0_address = addr;
    avs_s0_read    = 1'b1;
    @(negedge clk);
    avs_s0_read    = 1'b0;
    data           = avs_s0_readdata;
  endtask

  task automatic wait_neg(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [31:0] rd;
  logic [7:0]  bounce_exp [10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; avs_s0_address = '0; avs_s0_read = 1'b0; avs_s0_write = 1'b0;
    avs_s0_writedata = '0; button = 4'hF;
    wait_neg(3);
    reset = 1'b0;

    // Reset and read-back
    check_eq("rst_leds", {24'd0, leds}, 32'h0);
    bus_read(2'd0, rd); check_eq("rst_ctrl", rd, 32'h0);
    bus_read(2'd1, rd); check_eq("rst_pattern", rd, 32'h0);
    bus_read(2'd2, rd); check_eq("rst_period", rd, 32'd10);
    bus_read(2'd3, rd); check_eq("rst_status", rd, 32'h0);

    // Rotate-left, period 4; steps at edges 4, 8, 12 after the CTRL write
    bus_write(2'd1, 32'h81);
    check_eq("rot_load", {24'd0, leds}, 32'h81);
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h3);
    wait_neg(3); check_eq("rot_hold3", {24'd0, leds}, 32'h81);
    wait_neg(1); check_eq("rot_step1", {24'd0, leds}, 32'h03);
    wait_neg(4); check_eq("rot_step2", {24'd0, leds}, 32'h06);
    bus_read(2'd3, rd); check_eq("rot_status", rd, 32'h0002_0601);
    // Stop write lands on the edge where step 3 is due: no step
    bus_write(2'd0, 32'h2);
    check_eq("rot_stop", {24'd0, leds}, 32'h06);
    bus_read(2'd3, rd); check_eq("rot_status_idle", rd, 32'h0002_0600);

    // PATTERN write colliding with a due step
    bus_write(2'd1, 32'h01);
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h3);
    wait_neg(2);
    bus_write(2'd1, 32'h5A);
    check_eq("col_pattern", {24'd0, leds}, 32'h5A);
    wait_neg(1); check_eq("col_nostep", {24'd0, leds}, 32'h5A);
    bus_write(2'd0, 32'h2);

    // Bounce, period 1
    bounce_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    bus_write(2'd1, 32'h40);
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'h5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("bounce_%0d", i), {24'd0, leds}, {24'd0, bounce_exp[i]});
    end
    bus_write(2'd0, 32'h4);
    check_eq("bounce_stop", {24'd0, leds}, 32'h08);

    // Count with wrap, period 0
    bus_write(2'd1, 32'hFE);
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'h7);
    wait_neg(1); check_eq("cnt_ff", {24'd0, leds}, 32'hFF);
    wait_neg(1); check_eq("cnt_wrap", {24'd0, leds}, 32'h00);
    wait_neg(1); check_eq("cnt_01", {24'd0, leds}, 32'h01);
    bus_write(2'd0, 32'h6);
    check_eq("cnt_stop", {24'd0, leds}, 32'h02);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd); check_eq("status_ro", rd, 32'h0004_0200);
    bus_read(2'd2, rd); check_eq("period_zero", rd, 32'h0);
    bus_read(2'd0, rd); check_eq("ctrl_rb", rd, 32'h6);

    // Pause/resume: rotate with period 2 (steps on even edges)
    bus_write(2'd1, 32'h01);
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'h3);
    button = 4'b1110;          // 5-cycle glitch
    wait_neg(5);
    button = 4'b1111;
    wait_neg(15);
    check_eq("glitch_ignored", {24'd0, leds}, 32'h04);
    button = 4'b1110;          // press held 12 cycles
    wait_neg(12);
    button = 4'b1111;
    wait_neg(8);
`ifdef LED_PATTERN_BUTTON_EN
    check_eq("hold_leds", {24'd0, leds}, 32'h80);
    bus_read(2'd3, rd); check_eq("hold_status", rd, 32'h000F_8002);
`else
    check_eq("hold_leds", {24'd0, leds}, 32'h10);
    bus_read(2'd3, rd); check_eq("hold_status", rd, 32'h0014_1001);
`endif
    button = 4'b1110;          // second press
    wait_neg(11);
`ifdef LED_PATTERN_BUTTON_EN
    check_eq("resume_pre", {24'd0, leds}, 32'h80);
    wait_neg(1); check_eq("resume_step", {24'd0, leds}, 32'h01);
`else
    check_eq("resume_pre", {24'd0, leds}, 32'h04);
    wait_neg(1); check_eq("resume_step", {24'd0, leds}, 32'h08);
`endif
    button = 4'b1111;

    // Reset mid-sequence
    wait_neg(3);
    reset = 1'b1;
    wait_neg(1);
    reset = 1'b0;
    check_eq("mid_rst_leds", {24'd0, leds}, 32'h0);
    bus_read(2'd3, rd); check_eq("mid_rst_status", rd, 32'h0);
    bus_read(2'd2, rd); check_eq("mid_rst_period", rd, 32'd10);
    bus_read(2'd0, rd); check_eq("mid_rst_ctrl", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
